parity_check_rx: RTL and testbench

Receive-side partner of the team's parity generator. Deserialises a bit-strobed serial frame (start, DATA_WIDTH data bits LSB first, parity, stop) and checks the received parity bit against the XOR of the data bits. Presents each byte with its parity status on a valid/ready handshake and keeps a saturating parity-error count. Sits between the serial link front end and the byte-consuming datapath.

---
 rtl/parity_check_rx_if.sv | 35 +++
 rtl/parity_check_rx.sv | 143 ++++++++++++++
 tb/tb_parity_check_rx.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_check_rx_if.sv
// parity_check_rx_if: bundles the serial-in strobe, the byte-out handshake and
// the status outputs of parity_check_rx. The receiver takes the slave modport;
// the link front end / consumer side takes the master modport.
//
// Handshake: data_valid rises when a frame lands in the output register and
// stays high with data_out/parity_err/frame_err stable until a clock edge
// sees data_valid && data_ready; data_ready while data_valid=0 does nothing.
interface parity_check_rx_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ERR_CNT_WIDTH = 8
);
   logic                     rx_en;
   logic                     bit_valid;
   logic                     sdata_in;
   logic                     data_ready;
   logic [DATA_WIDTH-1:0]    data_out;
   logic                     data_valid;
   logic                     parity_err;
   logic                     overrun;
   logic [ERR_CNT_WIDTH-1:0] err_count;
   logic                     frame_err;
   logic [1:0]               state_dbg;   // receiver FSM state, observation only

   modport slave (
      input  rx_en, bit_valid, sdata_in, data_ready,
      output data_out, data_valid, parity_err, overrun, err_count, frame_err,
             state_dbg
   );

   modport master (
      output rx_en, bit_valid, sdata_in, data_ready,
      input  data_out, data_valid, parity_err, overrun, err_count, frame_err,
             state_dbg
   );
endinterface

// File: rtl/parity_check_rx.sv
// parity_check_rx: deserialises start / DATA_WIDTH data bits (LSB first) /
// parity / stop frames strobed by bit_valid, checks parity, and presents each
// word on a valid/ready output register with a sticky overrun flag and a
// saturating parity-error counter.
// Optional macro PARITY_CHECK_RX_FRAMING_CHECK_EN: when defined the stop bit
// is checked and frame_err reports a 0 stop bit; otherwise frame_err is 0.
module parity_check_rx #(
   parameter int DATA_WIDTH    = 8,
   parameter int ODD_PARITY    = 0,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   parity_check_rx_if.slave  bus
);

   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic ODD = (ODD_PARITY != 0);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2, STOP = 2'd3} state_t;

   state_t                   state_q, state_d;
   logic [DATA_WIDTH-1:0]    shreg_q;
   logic [CW-1:0]            cnt_q;
   logic                     xor_q;
   logic                     mism_q;
   logic [DATA_WIDTH-1:0]    data_q;
   logic                     valid_q;
   logic                     perr_q;
   logic                     ovr_q;
   logic [ERR_CNT_WIDTH-1:0] errcnt_q;

   logic frame_done;
   logic load;
   logic drop;
   logic accept;
   logic stop_bad;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: only strobed bits advance the frame
   always_comb begin
      state_d = state_q;
      if (bus.bit_valid) begin
         case (state_q)
            IDLE:    if (!bus.sdata_in && bus.rx_en) state_d = DATA;
            DATA:    if (cnt_q == LAST_BIT)          state_d = PAR;
            PAR:     state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Frame completion and output-register decisions
   always_comb begin
      frame_done = (state_q == STOP) && bus.bit_valid;
      accept     = valid_q && bus.data_ready;
      load       = frame_done && (!valid_q || bus.data_ready);
      drop       = frame_done && valid_q && !bus.data_ready;
`ifdef PARITY_CHECK_RX_FRAMING_CHECK_EN
      stop_bad   = !bus.sdata_in;
`else
      stop_bad   = 1'b0;
`endif
   end

   // Shift register, bit counter and running parity
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         xor_q   <= 1'b0;
         mism_q  <= 1'b0;
      end else if (bus.bit_valid) begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               xor_q <= 1'b0;
            end
            DATA: begin
               // Right shift: the first data bit ends up in bit 0
               shreg_q <= {bus.sdata_in, shreg_q[DATA_WIDTH-1:1]};
               xor_q   <= xor_q ^ bus.sdata_in;
               cnt_q   <= cnt_q + CW'(1);
            end
            PAR:     mism_q <= xor_q ^ bus.sdata_in ^ ODD;
            default: ;
         endcase
      end
   end

   // Output register, handshake, overrun and error counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q   <= '0;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         errcnt_q <= '0;
      end else begin
         if (load) begin
            data_q  <= shreg_q;
            perr_q  <= mism_q;
            valid_q <= 1'b1;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
         if (drop) ovr_q <= 1'b1;
         // Dropped frames still count; the counter sticks at all-ones
         if (frame_done && mism_q && (errcnt_q != CNT_MAX))
            errcnt_q <= errcnt_q + ERR_CNT_WIDTH'(1);
      end
   end

`ifdef PARITY_CHECK_RX_FRAMING_CHECK_EN
   logic ferr_q;

   // Framing status travels with the word it describes
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     ferr_q <= 1'b0;
      else if (load) ferr_q <= stop_bad;
   end

   assign bus.frame_err = ferr_q;
`else
   assign bus.frame_err = 1'b0;
`endif

   assign bus.data_out   = data_q;
   assign bus.data_valid = valid_q;
   assign bus.parity_err = perr_q;
   assign bus.overrun    = ovr_q;
   assign bus.err_count  = errcnt_q;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_parity_check_rx.sv
// tb_parity_check_rx: three receivers (even parity, odd parity, 2-bit error
// counter) share one serial stream and consumer. A frame-level model predicts
// every output each cycle; literal checks pin key points of the model.
module tb_parity_check_rx;

   logic clk = 1'b0;
   logic reset;
   logic rx_en, bit_valid, sdata_in, data_ready;

   // Frame currently completing (set by the driver for the stop-bit edge)
   logic       pend;
   logic [7:0] pend_data;
   logic       pend_par;
   logic       pend_stop;

   int n_vec = 0;
   int n_mis = 0;

   parity_check_rx_if #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) if0 ();
   parity_check_rx_if #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) if1 ();
   parity_check_rx_if #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) if2 ();

   parity_check_rx #(.DATA_WIDTH(8), .ODD_PARITY(0), .ERR_CNT_WIDTH(8))
      u0 (.clk(clk), .reset(reset), .bus(if0));
   parity_check_rx #(.DATA_WIDTH(8), .ODD_PARITY(1), .ERR_CNT_WIDTH(8))
      u1 (.clk(clk), .reset(reset), .bus(if1));
   parity_check_rx #(.DATA_WIDTH(8), .ODD_PARITY(0), .ERR_CNT_WIDTH(2))
      u2 (.clk(clk), .reset(reset), .bus(if2));

   assign if0.rx_en = rx_en;  assign if0.bit_valid = bit_valid;
   assign if0.sdata_in = sdata_in;  assign if0.data_ready = data_ready;
   assign if1.rx_en = rx_en;  assign if1.bit_valid = bit_valid;
   assign if1.sdata_in = sdata_in;  assign if1.data_ready = data_ready;
   assign if2.rx_en = rx_en;  assign if2.bit_valid = bit_valid;
   assign if2.sdata_in = sdata_in;  assign if2.data_ready = data_ready;

   // Clock
   always #5 clk = ~clk;

   // ---------------- model (frame level) ----------------
   int         odd_p [3] = '{0, 1, 0};
   int         cmax  [3] = '{255, 255, 3};
   logic       m_valid [3];
   logic [7:0] m_data  [3];
   logic       m_perr  [3];
   logic       m_ferr  [3];
   logic       m_ovr   [3];
   int         m_cnt   [3];

   function automatic logic mismatch(input logic [7:0] d, input logic p, input int odd);
      int ones;
      ones = $countones(d);
      // The correct parity bit makes the total count of ones even (or odd)
      return (p != logic'((ones % 2) ^ odd));
   endfunction

   function automatic logic exp_ferr(input logic stop);
`ifdef PARITY_CHECK_RX_FRAMING_CHECK_EN
      return !stop;
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            m_valid[i] <= 1'b0; m_data[i] <= 8'h00; m_perr[i] <= 1'b0;
            m_ferr[i]  <= 1'b0; m_ovr[i]  <= 1'b0;  m_cnt[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (pend && bit_valid) begin
               if (!m_valid[i] || data_ready) begin
                  m_valid[i] <= 1'b1;
                  m_data[i]  <= pend_data;
                  m_perr[i]  <= mismatch(pend_data, pend_par, odd_p[i]);
                  m_ferr[i]  <= exp_ferr(pend_stop);
               end else begin
                  m_ovr[i] <= 1'b1;
               end
               if (mismatch(pend_data, pend_par, odd_p[i]) && m_cnt[i] < cmax[i])
                  m_cnt[i] <= m_cnt[i] + 1;
            end else if (m_valid[i] && data_ready) begin
               m_valid[i] <= 1'b0;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s[u%0d] @%0t: got %0h, expected %0h", name, inst, $time, act, exp);
      end
   endtask

   logic [7:0] a_data [3];
   logic       a_valid [3], a_perr [3], a_ferr [3], a_ovr [3];
   logic [7:0] a_cnt [3];
   assign a_data[0] = if0.data_out;   assign a_data[1] = if1.data_out;   assign a_data[2] = if2.data_out;
   assign a_valid[0] = if0.data_valid; assign a_valid[1] = if1.data_valid; assign a_valid[2] = if2.data_valid;
   assign a_perr[0] = if0.parity_err; assign a_perr[1] = if1.parity_err; assign a_perr[2] = if2.parity_err;
   assign a_ferr[0] = if0.frame_err;  assign a_ferr[1] = if1.frame_err;  assign a_ferr[2] = if2.frame_err;
   assign a_ovr[0] = if0.overrun;     assign a_ovr[1] = if1.overrun;     assign a_ovr[2] = if2.overrun;
   assign a_cnt[0] = if0.err_count;   assign a_cnt[1] = if1.err_count;   assign a_cnt[2] = {6'd0, if2.err_count};

   logic run_cmp = 1'b0;

   // Compare every output of every instance on the falling edge
   always @(negedge clk) begin
      if (run_cmp) begin
         for (int i = 0; i < 3; i++) begin
            chk("data_valid", i, 32'(a_valid[i]), 32'(m_valid[i]));
            chk("data_out",   i, 32'(a_data[i]),  32'(m_data[i]));
            chk("parity_err", i, 32'(a_perr[i]),  32'(m_perr[i]));
            chk("frame_err",  i, 32'(a_ferr[i]),  32'(m_ferr[i]));
            chk("overrun",    i, 32'(a_ovr[i]),   32'(m_ovr[i]));
            chk("err_count",  i, 32'(a_cnt[i]),   32'(m_cnt[i]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic put_bit(input logic b, input logic last);
      bit_valid = 1'b1;
      sdata_in  = b;
      pend      = last;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      pend      = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // gap_at >= 0 inserts one unstrobed cycle after that data bit index;
   // drop_en drops rx_en for the body of the frame
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                             input int gap_at, input logic drop_en);
      pend_data = d; pend_par = p; pend_stop = s;
      put_bit(1'b0, 1'b0);
      if (drop_en) rx_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         put_bit(d[i], 1'b0);
         if (i == gap_at) idle(1);
      end
      put_bit(p, 1'b0);
      put_bit(s, 1'b1);
      rx_en = 1'b1;
   endtask

   task automatic send_partial(input logic [7:0] d, input int nbits);
      put_bit(1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) put_bit(d[i], 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1; rx_en = 1'b1; bit_valid = 1'b0; sdata_in = 1'b1;
      data_ready = 1'b1; pend = 1'b0; pend_data = 8'h00; pend_par = 1'b0; pend_stop = 1'b1;
      #1;
      run_cmp = 1'b1;
      idle(3);
      chk("lit_reset_valid", 0, 32'(if0.data_valid), 32'd0);
      chk("lit_reset_cnt",   0, 32'(if0.err_count),  32'd0);
      reset = 1'b0;
      idle(2);

      // 0xA5, correct even parity
      send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b0);
      chk("lit_a5_data",  0, 32'(if0.data_out),   32'hA5);
      chk("lit_a5_valid", 0, 32'(if0.data_valid), 32'd1);
      chk("lit_a5_perr",  0, 32'(if0.parity_err), 32'd0);
      idle(1);
      chk("lit_a5_fall",  0, 32'(if0.data_valid), 32'd0);
      chk("lit_a5_cnt",   0, 32'(if0.err_count),  32'd0);

      // Same byte with parity 1: bad for even, good for odd
      send_frame(8'hA5, 1'b1, 1'b1, 3, 1'b0);
      chk("lit_bad_perr", 0, 32'(if0.parity_err), 32'd1);
      chk("lit_bad_cnt",  0, 32'(if0.err_count),  32'd1);
      chk("lit_odd_perr", 1, 32'(if1.parity_err), 32'd0);
      chk("lit_odd_cnt",  1, 32'(if1.err_count),  32'd1);

      // Back-to-back frames, rx_en dropped mid-frame, with stalls
      send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b1);
      send_frame(8'h81, 1'b0, 1'b1, 7, 1'b0);
      chk("lit_b2b_data", 0, 32'(if0.data_out), 32'h81);
      idle(2);

      // Start bit with rx_en low is discarded, idle ones are ignored
      rx_en = 1'b0;
      put_bit(1'b0, 1'b0);
      rx_en = 1'b1;
      put_bit(1'b1, 1'b0);
      put_bit(1'b1, 1'b0);
      idle(1);

      // Overrun: consumer stalled across two frames
      data_ready = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0);
      send_frame(8'h81, 1'b0, 1'b1, -1, 1'b0);
      idle(2);
      chk("lit_ovr_data", 0, 32'(if0.data_out), 32'h3C);
      chk("lit_ovr_flag", 0, 32'(if0.overrun),  32'd1);
      data_ready = 1'b1;
      idle(1);
      chk("lit_ovr_fall", 0, 32'(if0.data_valid), 32'd0);
      chk("lit_ovr_keep", 0, 32'(if0.overrun),    32'd1);
      idle(2);

      // Saturation of the 2-bit counter (clean start)
      reset = 1'b1; idle(1); reset = 1'b0; idle(1);
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'h01, 1'b0, 1'b1, -1, 1'b0);
         if (k == 3) chk("lit_sat3", 2, 32'(if2.err_count), 32'd3);
      end
      idle(1);
      chk("lit_sat5", 2, 32'(if2.err_count), 32'd3);
      chk("lit_cnt5", 0, 32'(if0.err_count), 32'd5);

      // Reset in the middle of a frame
      send_partial(8'h77, 4);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      chk("lit_rst_cnt", 0, 32'(if0.err_count), 32'd0);
      send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b0);
      chk("lit_5a_data", 0, 32'(if0.data_out),   32'h5A);
      chk("lit_5a_perr", 0, 32'(if0.parity_err), 32'd0);
      chk("lit_5a_ovr",  0, 32'(if0.overrun),    32'd0);
      idle(1);

      // Stop bit 0 on 0xFF with correct parity
      send_frame(8'hFF, 1'b0, 1'b0, -1, 1'b0);
      chk("lit_ff_data", 0, 32'(if0.data_out),   32'hFF);
      chk("lit_ff_perr", 0, 32'(if0.parity_err), 32'd0);
      chk("lit_ff_cnt",  0, 32'(if0.err_count),  32'd0);
`ifdef PARITY_CHECK_RX_FRAMING_CHECK_EN
      chk("lit_ff_ferr", 0, 32'(if0.frame_err),  32'd1);
`else
      chk("lit_ff_ferr", 0, 32'(if0.frame_err),  32'd0);
`endif
      idle(3);

      run_cmp = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
